// File: rtl/ram2stream_dma.sv
// Read-side DMA: streams num_elements consecutive RAM words starting at src_addr
// out over a valid/ready interface, one word per cycle when the consumer keeps up.
module ram2stream_dma #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8,
  localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] src_addr,
  input  logic [ADDR_WIDTH:0]   num_elements,
  output logic                  busy,
  output logic                  done,
  output logic                  ram_rd_en,
  output logic [ADDR_WIDTH-1:0] ram_rd_addr,
  input  logic [DATA_WIDTH-1:0] ram_rd_data,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [1:0]            dbg_state
);

  // Stream handshake: a beat transfers on a rising clk edge where m_valid && m_ready;
  // m_valid/m_data come straight from the FIFO head and never depend on m_ready.
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] src_q;
  logic [ADDR_WIDTH:0]   num_q;
  logic [ADDR_WIDTH:0]   rd_count;
  logic                  in_flight;
  logic [DATA_WIDTH-1:0] fifo_mem [2];
  logic                  wr_ptr, rd_ptr;
  logic [1:0]            fifo_count;
  logic [1:0]            occupancy;
  logic                  pop, issue;

  assign m_valid     = (fifo_count != 2'd0);
  assign m_data      = fifo_mem[rd_ptr];
  assign pop         = m_valid && m_ready;
  assign occupancy   = fifo_count + {1'b0, in_flight};
  assign ram_rd_en   = issue;
  assign ram_rd_addr = src_q + rd_count[ADDR_WIDTH-1:0];
  assign busy        = (state == RUN) || (state == DRAIN);
  assign done        = (state == DONE);
  assign dbg_state   = state;

  // A slot is counted as taken from the moment its read is issued, so the
  // 2-entry FIFO can never overflow whatever the consumer does.
  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = (num_elements == '0) ? DONE : RUN;
      end
      RUN: begin
        issue = (rd_count < num_q) &&
                ((occupancy < 2'd2) || ((occupancy == 2'd2) && pop));
        if (issue && (rd_count == num_q - 1'b1)) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (pop && (fifo_count == 2'd1) && !in_flight) state_nxt = DONE;
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      src_q       <= '0;
      num_q       <= '0;
      rd_count    <= '0;
      in_flight   <= 1'b0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      fifo_count  <= 2'd0;
      fifo_mem[0] <= '0;
      fifo_mem[1] <= '0;
    end else begin
      state <= state_nxt;
      if ((state == IDLE) && start) begin
        src_q    <= src_addr;
        num_q    <= num_elements;
        rd_count <= '0;
      end else if (issue) begin
        rd_count <= rd_count + 1'b1;
      end
      // RAM data arrives the cycle after the strobe; capture it then.
      in_flight <= issue;
      if (in_flight) begin
        fifo_mem[wr_ptr] <= ram_rd_data;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      fifo_count <= fifo_count + {1'b0, in_flight} - {1'b0, pop};
    end
  end

endmodule

// File: tb/tb_ram2stream_dma.sv
// Directed bench for ram2stream_dma: scoreboard queues of expected beats and read
// addresses, drained by a negedge monitor independent of the stimulus tasks.
module tb_ram2stream_dma;
  localparam int DW    = 8;
  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [AW-1:0] src_addr;
  logic [AW:0]   num_elements;
  logic          busy, done, ram_rd_en;
  logic [AW-1:0] ram_rd_addr;
  logic [DW-1:0] ram_rd_data;
  logic [DW-1:0] m_data;
  logic          m_valid, m_ready;
  logic [1:0]    dbg_state;

  logic [DW-1:0] ram [DEPTH];
  logic [DW-1:0] exp_q[$];
  logic [AW-1:0] addr_q[$];

  int tests = 0, fails = 0;
  int cyc = 0, done_due = -1, outstanding = 0;
  int start_cyc = 0, first_valid_cyc = -1, first_pop_cyc = -1, last_pop_cyc = -1, pop_cnt = 0;
  logic rand_ready = 1'b0;
  logic prev_stall = 1'b0;
  logic [DW-1:0] prev_data = '0;

  ram2stream_dma #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .start(start), .src_addr(src_addr),
    .num_elements(num_elements), .busy(busy), .done(done),
    .ram_rd_en(ram_rd_en), .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .dbg_state(dbg_state)
  );

  // clock / reset / RAM model
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (ram_rd_en) ram_rd_data <= ram[ram_rd_addr];

  always @(posedge clk) begin
    #1;
    m_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (!reset) begin
      if (done_due == cyc) check("done_pulse", done, 1);
      else if (done) check("done_unexpected", done, 0);
      if (ram_rd_en) begin
        if (addr_q.size() == 0) check("unexpected_read", ram_rd_en, 0);
        else check("rd_addr", ram_rd_addr, addr_q.pop_front());
        check("no_overflow", (outstanding < 2) || (outstanding == 2 && m_valid && m_ready), 1);
      end
      if (prev_stall) begin
        check("stall_valid", m_valid, 1);
        check("stall_data", m_data, prev_data);
      end
      if (m_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) check("unexpected_beat", m_valid, 0);
        else begin
          check("beat_data", m_data, exp_q.pop_front());
          if (exp_q.size() == 0) done_due = cyc + 1;
        end
        if (pop_cnt == 0) first_pop_cyc = cyc;
        last_pop_cyc = cyc;
        pop_cnt++;
      end
      outstanding = outstanding + int'(ram_rd_en) - int'(m_valid && m_ready);
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
    end
  end

  // driver tasks (all called at posedge+1)
  task automatic do_reset();
    reset = 1'b1;
    exp_q.delete();
    addr_q.delete();
    outstanding = 0;
    done_due = -1;
    prev_stall = 1'b0;
    @(posedge clk); #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_rd_en", ram_rd_en, 0);
    check("rst_rd_addr", ram_rd_addr, 0);
    check("rst_m_valid", m_valid, 0);
    check("rst_m_data", m_data, 0);
    check("rst_state", dbg_state, 0);
    reset = 1'b0;
  endtask

  task automatic start_xfer(input int src, input int n);
    logic [AW-1:0] a;
    @(posedge clk); #1;
    start = 1'b1;
    src_addr = AW'(src);
    num_elements = (AW+1)'(n);
    start_cyc = cyc;
    first_valid_cyc = -1;
    pop_cnt = 0;
    for (int i = 0; i < n; i++) begin
      a = AW'((src + i) % DEPTH);
      addr_q.push_back(a);
      exp_q.push_back(ram[a]);
    end
    if (n == 0) done_due = cyc + 1;
    @(posedge clk); #1;
    start = 1'b0;
    src_addr = AW'($urandom_range(0, DEPTH-1));
    num_elements = (AW+1)'($urandom_range(0, DEPTH));
  endtask

  task automatic wait_idle();
    bit idle = 0;
    for (int i = 0; i < 200 && !idle; i++) begin
      @(posedge clk); #1;
      idle = !busy && !done && exp_q.size() == 0 && addr_q.size() == 0;
    end
    check("idle_within_bound", idle, 1);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; src_addr = '0; num_elements = '0; m_ready = 1'b1;
    ram_rd_data = '0;
    for (int i = 0; i < DEPTH; i++) ram[i] = DW'(i + 8'h10);
    do_reset();

    // 1: basic, full rate
    start_xfer(2, 4);
    wait_idle();
    check("t1_first_valid_latency", first_valid_cyc - start_cyc, 3);
    check("t1_beats", pop_cnt, 4);
    check("t1_back_to_back", last_pop_cyc - first_pop_cyc, 3);
    check("t1_busy_after", busy, 0);

    // 2: address wrap
    start_xfer(6, 4);
    wait_idle();
    check("t2_beats", pop_cnt, 4);

    // 3: full depth with random backpressure
    rand_ready = 1'b1;
    start_xfer(3, 8);
    wait_idle();
    check("t3_beats", pop_cnt, 8);
    rand_ready = 1'b0;

    // 4: zero length, then start while busy
    start_xfer(0, 0);
    wait_idle();
    check("t4_zero_beats", pop_cnt, 0);
    start_xfer(4, 5);
    start = 1'b1; src_addr = '0; num_elements = 4'd3;
    @(posedge clk); #1;
    start = 1'b0;
    wait_idle();
    check("t4_busy_start_beats", pop_cnt, 5);

    // 5: reset mid-transfer, then clean restart
    start_xfer(0, 6);
    for (int i = 0; i < 50 && pop_cnt < 2; i++) begin
      @(posedge clk); #1;
    end
    check("t5_reached_beat2", pop_cnt >= 2, 1);
    do_reset();
    @(posedge clk); #1;
    check("t5_post_rst_valid", m_valid, 0);
    check("t5_post_rst_busy", busy, 0);
    start_xfer(1, 2);
    wait_idle();
    check("t5_restart_beats", pop_cnt, 2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
